// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Frames drain back-to-back
// from the FIFO using s_tick oversampling; parity mode is latched per frame.
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      parity_mode,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SMAX  = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW    = $clog2(SMAX);
  localparam int NW    = $clog2(DBIT);
  localparam logic [SW-1:0]    S_BIT_LAST  = SW'(OS - 1);
  localparam logic [SW-1:0]    S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]    N_LAST      = NW'(DBIT - 1);
  localparam logic [FIFO_AW:0] CNT_FULL    = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and pointers
  logic [DBIT-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count, count_next;
  logic               push, pop;
  logic [DBIT-1:0]    head;

  // Handshake: a word is accepted when wr_en is high and the registered full
  // flag is low; the FSM pops only when the registered empty flag is low.
  assign push = wr_en && !full;
  assign head = mem[rptr];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == CNT_FULL);
      empty    <= (count_next == '0);
      overflow <= wr_en && full;
    end
  end

  // Transmit FSM
  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] shift, shift_next;
  logic [1:0]      pmode, pmode_next;
  logic            pbit, pbit_next;
  logic            done_next, tx_next;
  logic            par_en;

  assign par_en = (pmode == 2'b01) || (pmode == 2'b10);

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    pmode_next = pmode;
    pbit_next  = pbit;
    pop        = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          pmode_next = parity_mode;
          pbit_next  = (^head) ^ (parity_mode == 2'b10);
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == N_LAST) state_next = par_en ? PARITY : STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            done_next = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (!empty) begin
              pop        = 1'b1;
              shift_next = head;
              pmode_next = parity_mode;
              pbit_next  = (^head) ^ (parity_mode == 2'b10);
              s_next     = '0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx is registered and
  // moves on the same edge as the state transition.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = pbit_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      pmode        <= 2'b00;
      pbit         <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      shift        <= shift_next;
      pmode        <= pmode_next;
      pbit         <= pbit_next;
      tx           <= tx_next;
      busy         <= (state_next != IDLE);
      tx_done_tick <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: tick-level waveform model for the default instance,
// plus hand-computed frame checks on a 5-bit / 2-stop-bit instance.
module tb_uart_tx_fifo;

  localparam int OS1   = 16;
  localparam int SB1   = 16;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tick_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       wr_en1 = 1'b0, wr_en2 = 1'b0;
  logic [7:0] din1 = '0;
  logic [4:0] din2 = '0;
  logic full1, empty1, ovf1, busy1, done1, tx1;
  logic full2, empty2, ovf2, busy2, done2, tx2;

  uart_tx_fifo dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .wr_en(wr_en1), .din(din1),
    .parity_mode(parity_mode), .full(full1), .empty(empty1), .overflow(ovf1),
    .busy(busy1), .tx_done_tick(done1), .tx(tx1)
  );

  uart_tx_fifo #(.DBIT(5), .OS(16), .SB_TICK(32), .FIFO_AW(2)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .wr_en(wr_en2), .din(din2),
    .parity_mode(parity_mode), .full(full2), .empty(empty2), .overflow(ovf2),
    .busy(busy2), .tx_done_tick(done2), .tx(tx2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares < 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // baud tick: one pulse every 4 clocks while enabled
  int tcnt = 0;
  always @(negedge clk) begin
    tcnt   = (tcnt + 1) % 4;
    s_tick = tick_en && (tcnt == 0);
  end

  // pulse counters for the default instance
  int n_done = 0, n_ovf = 0;
  always @(posedge clk) begin
    if (done1) n_done++;
    if (ovf1)  n_ovf++;
  end

  // scoreboard model: exp_q holds queued words, lvl holds the line level for
  // every remaining s_tick of the frame in flight
  logic [7:0] exp_q[$];
  logic       lvl[$];
  logic       m_tx = 1'b1, m_full = 1'b0, m_empty = 1'b1, m_ovf = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic       mvalid = 1'b0;

  task automatic build_frame(input logic [7:0] w, input logic [1:0] pm);
    for (int i = 0; i < OS1; i++) lvl.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < OS1; i++) lvl.push_back(w[b]);
    if (pm == 2'b01 || pm == 2'b10)
      for (int i = 0; i < OS1; i++) lvl.push_back((^w) ^ (pm == 2'b10));
    for (int i = 0; i < SB1; i++) lvl.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    logic pre_full, load, tmp;
    logic [7:0] w;
    if (reset) begin
      exp_q.delete();
      lvl.delete();
      m_ovf  = 1'b0;
      m_done = 1'b0;
      mvalid = 1'b1;
    end else begin
      pre_full = (exp_q.size() == DEPTH);
      m_done = 1'b0;
      m_ovf  = 1'b0;
      load   = 1'b0;
      if (lvl.size() > 0) begin
        if (s_tick) begin
          tmp = lvl.pop_front();
          if (lvl.size() == 0) begin
            m_done = 1'b1;
            load   = (exp_q.size() > 0);
          end
        end
      end else begin
        load = (exp_q.size() > 0);
      end
      if (load) begin
        w = exp_q.pop_front();
        build_frame(w, parity_mode);
      end
      if (wr_en1) begin
        if (pre_full) m_ovf = 1'b1;
        else          exp_q.push_back(din1);
      end
    end
    m_tx    = (lvl.size() > 0) ? lvl[0] : 1'b1;
    m_busy  = (lvl.size() > 0);
    m_full  = (exp_q.size() == DEPTH);
    m_empty = (exp_q.size() == 0);
  end

  // per-cycle compare of the default instance against the model
  always @(negedge clk) begin
    if (mvalid)
      check("cycle{tx,full,empty,ovf,busy,done}",
            16'({tx1, full1, empty1, ovf1, busy1, done1}),
            16'({m_tx, m_full, m_empty, m_ovf, m_busy, m_done}));
  end

  // driver tasks
  task automatic push1(input logic [7:0] d);
    @(negedge clk);
    wr_en1 = 1'b1;
    din1   = d;
    @(negedge clk);
    wr_en1 = 1'b0;
  endtask

  // Records the line level at the first tick of each bit slot and counts
  // ticks from the start bit until tx_done_tick is seen.
  task automatic capture(input int sel, input int os, output logic [15:0] bits, output int ticks);
    logic started, got, t, d;
    bits = '0;
    ticks = 0;
    started = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(posedge clk);
      t = sel ? tx2 : tx1;
      d = sel ? done2 : done1;
      if (started && d) begin
        got = 1'b1;
      end else begin
        if (!started && t == 1'b0) started = 1'b1;
        if (started && s_tick) begin
          if (ticks % os == 0 && ticks / os < 16) bits[ticks / os] = t;
          ticks++;
        end
      end
    end
    check("capture_done_seen", 16'(got), 16'd1);
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  logic [15:0] bits;
  int          ticks;
  int          d0, o0;

  initial begin
    // reset
    wait_clks(3);
    reset = 1'b0;
    check("reset_tx", 16'(tx1), 16'd1);
    check("reset_empty", 16'(empty1), 16'd1);
    check("reset_full", 16'(full1), 16'd0);
    check("reset_busy", 16'(busy1), 16'd0);
    check("reset_ovf_done", 16'({ovf1, done1}), 16'd0);

    // even parity, 0x53, with push-to-start latency
    tick_en = 1'b1;
    parity_mode = 2'b01;
    d0 = n_done;
    push1(8'h53);
    check("lat_empty_after_push", 16'(empty1), 16'd0);
    check("lat_tx_still_idle", 16'(tx1), 16'd1);
    @(negedge clk);
    check("lat_tx_start", 16'(tx1), 16'd0);
    capture(0, 16, bits, ticks);
    check("even_bits", bits & 16'h07FF, 16'h04A6);
    check("even_ticks", 16'(ticks), 16'd176);
    wait_clks(3);
    check("even_done_count", 16'(n_done - d0), 16'd1);
    check("even_busy_after", 16'(busy1), 16'd0);

    // odd parity latched; mode changed mid-frame and ticks held off in START
    wait_clks(8);
    tick_en = 1'b0;
    parity_mode = 2'b10;
    push1(8'h53);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 50) check("hold_start_tx", 16'(tx1), 16'd0);
    end
    parity_mode = 2'b00;
    tick_en = 1'b1;
    capture(0, 16, bits, ticks);
    check("odd_bits", bits & 16'h07FF, 16'h06A6);
    check("odd_ticks", 16'(ticks), 16'd176);

    // no parity
    wait_clks(8);
    push1(8'h53);
    capture(0, 16, bits, ticks);
    check("none_bits", bits & 16'h03FF, 16'h02A6);
    check("none_ticks", 16'(ticks), 16'd160);

    // burst of six pushes from idle: first pops at once, four fill the FIFO,
    // the sixth is dropped
    wait_clks(8);
    parity_mode = 2'b01;
    d0 = n_done;
    o0 = n_ovf;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      wr_en1 = 1'b1;
      din1   = 8'(i);
    end
    @(negedge clk);
    wr_en1 = 1'b0;
    check("burst_full", 16'(full1), 16'd1);
    check("burst_ovf_pulse", 16'(ovf1), 16'd1);
    for (int c = 0; c < 8000 && (n_done - d0) < 5; c++) @(negedge clk);
    wait_clks(10);
    check("burst_done_count", 16'(n_done - d0), 16'd5);
    check("burst_ovf_count", 16'(n_ovf - o0), 16'd1);
    check("burst_idle", 16'({busy1, empty1}), 16'b01);

    // reset during data bit 3 with two words queued
    push1(8'hA1);
    push1(8'hB2);
    push1(8'hC3);
    begin
      int tk;
      logic st;
      tk = 0;
      st = 1'b0;
      for (int c = 0; c < 2000 && tk < 70; c++) begin
        @(posedge clk);
        if (!st && tx1 == 1'b0) st = 1'b1;
        if (st && s_tick) tk++;
      end
      check("mid_reset_reached", 16'(tk), 16'd70);
    end
    d0 = n_done;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_tx", 16'(tx1), 16'd1);
    check("mid_reset_empty", 16'(empty1), 16'd1);
    check("mid_reset_busy", 16'(busy1), 16'd0);
    check("mid_reset_done", 16'(done1), 16'd0);
    wait_clks(200);
    check("mid_reset_no_done", 16'(n_done - d0), 16'd0);
    push1(8'h53);
    capture(0, 16, bits, ticks);
    check("after_reset_bits", bits & 16'h07FF, 16'h04A6);
    check("after_reset_ticks", 16'(ticks), 16'd176);

    // 5 data bits, 2 stop bits, no parity, on the second instance
    wait_clks(8);
    parity_mode = 2'b00;
    @(negedge clk);
    wr_en2 = 1'b1;
    din2   = 5'h1F;
    @(negedge clk);
    wr_en2 = 1'b0;
    capture(1, 16, bits, ticks);
    check("d5_bits", bits & 16'h00FF, 16'h00FE);
    check("d5_ticks", 16'(ticks), 16'd128);
    wait_clks(3);
    check("d5_idle", 16'({busy2, empty2, tx2}), 16'b011);

    wait_clks(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
